// File: rtl/io_bank_pkg.sv
// io_bank_pkg: shared constants for the multi-pad GPIO IO tile.
// Build option: IO_BANK_PARITY_EN adds one even-parity bit at the top of the chain.
package io_bank_pkg;

   localparam int CFG_BITS_PER_PAD = 3;
   localparam int CFG_DIR          = 0;
   localparam int CFG_IN_REG       = 1;
   localparam int CFG_OUT_REG      = 2;

   // Total configuration chain length for a bank of num_pads pads.
   function automatic int chain_len(input int num_pads);
`ifdef IO_BANK_PARITY_EN
      return num_pads * CFG_BITS_PER_PAD + 1;
`else
      return num_pads * CFG_BITS_PER_PAD;
`endif
   endfunction

endpackage

// File: rtl/GPIO.sv
// GPIO: single bidirectional pad cell, drives A when DIR=1, always reads the pad.
module GPIO (
   inout  wire logic PAD,
   input  logic      A,
   input  logic      DIR,
   output logic      Y
);

   assign PAD = DIR ? A : 1'bz;
   assign Y   = PAD;

endmodule

// File: rtl/io_bank_cfg_chain.sv
// io_bank_cfg_chain: serial config chain with internal bit counter and atomic commit.
// Build option: IO_BANK_PARITY_EN checks even parity over the whole chain at commit.
module io_bank_cfg_chain
   import io_bank_pkg::*;
#(
   parameter int NUM_PADS = 8
) (
   input  logic                                   prog_clk,
   input  logic                                   pReset,
   input  logic                                   ccff_en,
   input  logic                                   ccff_head,
   output logic                                   ccff_tail,
   output logic [NUM_PADS*CFG_BITS_PER_PAD-1:0]   active_cfg,
   output logic                                   cfg_valid,
   output logic                                   cfg_done,
   output logic                                   cfg_err
);

   localparam int CHAIN_LEN = chain_len(NUM_PADS);
   localparam int PAD_BITS  = NUM_PADS * CFG_BITS_PER_PAD;
   localparam int CW        = $clog2(CHAIN_LEN);
   localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

   logic [CHAIN_LEN-1:0] chain;
   logic [CHAIN_LEN-1:0] chain_nxt;
   logic [CW-1:0]        bit_cnt;
   logic                 commit;
   logic                 parity_ok;
   logic                 done_pend;

   assign chain_nxt = {chain[CHAIN_LEN-2:0], ccff_head};
   assign commit    = ccff_en && (bit_cnt == LAST);
   assign ccff_tail = chain[CHAIN_LEN-1];

`ifdef IO_BANK_PARITY_EN
   assign parity_ok = ~^chain_nxt;

   // Sticky parity error: set by a bad commit, cleared by the next good one.
   always_ff @(posedge prog_clk) begin
      if (pReset)      cfg_err <= 1'b0;
      else if (commit) cfg_err <= ~parity_ok;
   end
`else
   assign parity_ok = 1'b1;
   assign cfg_err   = 1'b0;
`endif

   // Shift, count and commit; the live config only moves on a good commit,
   // so pads keep their old mode while a new stream is loading.
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         chain      <= '0;
         bit_cnt    <= '0;
         active_cfg <= '0;
         cfg_valid  <= 1'b0;
         done_pend  <= 1'b0;
         cfg_done   <= 1'b0;
      end else begin
         if (ccff_en) begin
            chain   <= chain_nxt;
            bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
         end
         if (commit && parity_ok) begin
            active_cfg <= chain_nxt[PAD_BITS-1:0];
            cfg_valid  <= 1'b1;
         end
         // done trails the mode change by one cycle
         done_pend <= commit && parity_ok;
         cfg_done  <= done_pend;
      end
   end

endmodule

// File: rtl/logical_tile_io_bank_gpio.sv
// logical_tile_io_bank_gpio: NUM_PADS GPIO pads configured by one serial chain.
// Build option: IO_BANK_PARITY_EN enables a parity bit and sticky cfg_err.
module logical_tile_io_bank_gpio #(
   parameter int NUM_PADS         = 8,
   parameter int CFG_BITS_PER_PAD = 3
) (
   input  logic                prog_clk,
   input  logic                pReset,
   inout  wire logic [NUM_PADS-1:0] gfpga_pad_GPIO_PAD,
   input  logic [NUM_PADS-1:0] iopad_outpad,
   output logic [NUM_PADS-1:0] iopad_inpad,
   input  logic                ccff_en,
   input  logic                ccff_head,
   output logic                ccff_tail,
   output logic                cfg_valid,
   output logic                cfg_done,
   output logic                cfg_err
);

   import io_bank_pkg::CFG_DIR;
   import io_bank_pkg::CFG_IN_REG;
   import io_bank_pkg::CFG_OUT_REG;

   logic [NUM_PADS*CFG_BITS_PER_PAD-1:0] active_cfg;

   io_bank_cfg_chain #(.NUM_PADS(NUM_PADS)) u_cfg (
      .prog_clk   (prog_clk),
      .pReset     (pReset),
      .ccff_en    (ccff_en),
      .ccff_head  (ccff_head),
      .ccff_tail  (ccff_tail),
      .active_cfg (active_cfg),
      .cfg_valid  (cfg_valid),
      .cfg_done   (cfg_done),
      .cfg_err    (cfg_err)
   );

   for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
      localparam int B = i * CFG_BITS_PER_PAD;
      logic out_q, in_q;
      logic pad_oe, pad_a, pad_y;

      assign pad_oe = cfg_valid & active_cfg[B+CFG_DIR];
      assign pad_a  = active_cfg[B+CFG_OUT_REG] ? out_q : iopad_outpad[i];

      GPIO u_gpio (
         .PAD (gfpga_pad_GPIO_PAD[i]),
         .A   (pad_a),
         .DIR (pad_oe),
         .Y   (pad_y)
      );

      // Data registers sample every cycle; the mode bits only pick the path.
      always_ff @(posedge prog_clk) begin
         if (pReset) begin
            out_q <= 1'b0;
            in_q  <= 1'b0;
         end else begin
            out_q <= iopad_outpad[i];
            in_q  <= pad_y;
         end
      end

      assign iopad_inpad[i] = cfg_valid & (active_cfg[B+CFG_IN_REG] ? in_q : pad_y);
   end

endmodule

// File: tb/tb_logical_tile_io_bank_gpio.sv
// Scoreboard bench for logical_tile_io_bank_gpio (NUM_PADS=8).
// Optional IO_BANK_PARITY_EN adds the bad/good parity stream.
module tb_logical_tile_io_bank_gpio;

   localparam int NP = 8;
`ifdef IO_BANK_PARITY_EN
   localparam int CL = NP*3 + 1;
`else
   localparam int CL = NP*3;
`endif

   typedef struct packed {
      logic [NP-1:0] pad;
      logic [NP-1:0] inpad;
      logic          tail;
      logic          valid;
      logic          done;
      logic          err;
   } exp_t;

   logic prog_clk = 1'b0;
   logic pReset = 1'b1;
   logic ccff_en = 1'b0;
   logic ccff_head = 1'b0;
   logic [NP-1:0] outpad = '0;
   logic [NP-1:0] tb_drv = '0;
   logic [NP-1:0] tb_oe = '0;
   wire  [NP-1:0] pad_net;
   logic [NP-1:0] inpad;
   logic ccff_tail, cfg_valid, cfg_done, cfg_err;

   for (genvar i = 0; i < NP; i++) begin : g_tbpad
      assign pad_net[i] = tb_oe[i] ? tb_drv[i] : 1'bz;
   end

   logical_tile_io_bank_gpio #(.NUM_PADS(NP), .CFG_BITS_PER_PAD(3)) dut (
      .prog_clk           (prog_clk),
      .pReset             (pReset),
      .gfpga_pad_GPIO_PAD (pad_net),
      .iopad_outpad       (outpad),
      .iopad_inpad        (inpad),
      .ccff_en            (ccff_en),
      .ccff_head          (ccff_head),
      .ccff_tail          (ccff_tail),
      .cfg_valid          (cfg_valid),
      .cfg_done           (cfg_done),
      .cfg_err            (cfg_err)
   );

   always #5 prog_clk = ~prog_clk;

   // reference model: last CL shifted bits (oldest first) and a shift total
   logic          m_hist[$];
   int            m_total;
   logic [NP*3-1:0] m_cfg;
   logic          m_valid, m_done, m_pend, m_err;
   logic [NP-1:0] m_outq, m_inq, m_pad;

   exp_t sb[$];
   int errors = 0;
   int checks = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // state change at a clock edge, from the inputs present before it
   function automatic void model_edge();
      logic par;
      if (pReset) begin
         m_hist.delete();
         for (int k = 0; k < CL; k++) m_hist.push_back(1'b0);
         m_total = 0; m_cfg = '0; m_valid = 0; m_done = 0; m_pend = 0; m_err = 0;
         m_outq = '0; m_inq = '0;
      end else begin
         m_done = m_pend;
         m_pend = 0;
         m_inq  = m_pad;
         m_outq = outpad;
         if (ccff_en) begin
            m_hist.push_back(ccff_head);
            void'(m_hist.pop_front());
            m_total++;
            if (m_total % CL == 0) begin
               par = 1'b0;
`ifdef IO_BANK_PARITY_EN
               for (int k = 0; k < CL; k++) par ^= m_hist[k];
`endif
               if (!par) begin
                  for (int k = 0; k < NP*3; k++) m_cfg[k] = m_hist[CL-1-k];
                  m_valid = 1; m_pend = 1; m_err = 0;
               end else begin
                  m_err = 1;
               end
            end
         end
      end
   endfunction

   // one clock: update model, drive next inputs, queue expected outputs
   task automatic step(input logic rst, input logic en, input logic head);
      exp_t e;
      logic drv, dv;
      @(posedge prog_clk);
      model_edge();
      #1;
      pReset = rst; ccff_en = en; ccff_head = head;
      outpad = NP'($urandom);
      tb_drv = NP'($urandom);
      e = '0;
      for (int i = 0; i < NP; i++) begin
         drv = m_valid && m_cfg[3*i];
         dv  = m_cfg[3*i+2] ? m_outq[i] : outpad[i];
         m_pad[i] = drv ? dv : tb_drv[i];
         tb_oe[i] = !drv;
         e.inpad[i] = m_valid && (m_cfg[3*i+1] ? m_inq[i] : m_pad[i]);
      end
      e.pad = m_pad; e.tail = m_hist[0];
      e.valid = m_valid; e.done = m_done; e.err = m_err;
      sb.push_back(e);
   endtask

   task automatic shift_stream(input logic [CL-1:0] s, input bit gap);
      for (int k = CL-1; k >= 0; k--) begin
         step(1'b0, 1'b1, s[k]);
         if (gap) step(1'b0, 1'b0, ~s[k]);
      end
   endtask

   task automatic load(input logic [NP*3-1:0] cfg, input bit gap);
      logic [CL-1:0] s;
`ifdef IO_BANK_PARITY_EN
      s = {^cfg, cfg};
`else
      s = cfg;
`endif
      shift_stream(s, gap);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'($urandom));
   endtask

   function automatic logic [NP*3-1:0] rnd_cfg();
      logic [31:0] r;
      r = $urandom;
      return r[NP*3-1:0];
   endfunction

   // monitor: compare every presented cycle against the scoreboard head
   initial begin
      exp_t e;
      forever begin
         @(negedge prog_clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pad",       pad_net,   e.pad);
            chk("inpad",     inpad,     e.inpad);
            chk("ccff_tail", ccff_tail, e.tail);
            chk("cfg_valid", cfg_valid, e.valid);
            chk("cfg_done",  cfg_done,  e.done);
            chk("cfg_err",   cfg_err,   e.err);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [CL-1:0] s;
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      idle(3);
      // pad0 DIR, pad1 IN_REG
      load(24'h000011, 1'b0);
      idle(6);
      // gapped load, old config holds meanwhile
      load(rnd_cfg(), 1'b1);
      idle(4);
      // reset mid-load aborts and restarts the count
      for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'($urandom));
      step(1'b1, 1'b0, 1'b0);
      load(rnd_cfg(), 1'b0);
      idle(3);
      // walking one through to ccff_tail
      s = '0; s[CL-1] = 1'b1;
      shift_stream(s, 1'b0);
      for (int k = 0; k < CL + 2; k++) step(1'b0, 1'b1, 1'b0);
      // back-to-back streams
      for (int k = 0; k < 3; k++) load(rnd_cfg(), 1'b0);
      idle(3);
      // random enables, heads and occasional reset
      for (int k = 0; k < 400; k++)
         step(($urandom % 97) == 0, 1'($urandom), 1'($urandom));
      idle(2);
      load(rnd_cfg() | 24'h249249, 1'b0);
      idle(4);
`ifdef IO_BANK_PARITY_EN
      s = {~(^24'h0a5f31), 24'h0a5f31};
      shift_stream(s, 1'b0);
      idle(4);
      load(rnd_cfg(), 1'b0);
      idle(4);
`endif
      step(1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge prog_clk);
      chk("sb_drain", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/logical_tile_io_bank_gpio.md
# logical_tile_io_bank_gpio

Parametrised multi-pad IO tile: NUM_PADS GPIO pads driven by one internally counted configuration chain with an atomic commit, plus optional per-pad input and output data registers. It replaces the single-pad, single-DIR-bit IO tile in the tileable fabric's IO ring. It sits between the pad ring (`gfpga_pad_GPIO_PAD`) and the routing fabric. It is chained through `ccff_head`/`ccff_tail` like every other configurable tile.

## Interface
Parameters:
- `NUM_PADS`, default 8: pads in the bank, range 1..64.
- `CFG_BITS_PER_PAD`, default 3: fixed at 3; exposed for the package constant only.

Ports:
- `prog_clk`, input, 1: the single clock, used for both configuration and data registers.
- `pReset`, input, 1: synchronous, active-high reset.
- `gfpga_pad_GPIO_PAD`, inout, NUM_PADS: pad pins.
- `iopad_outpad`, input, NUM_PADS: fabric-to-pad data.
- `iopad_inpad`, output, NUM_PADS: pad-to-fabric data.
- `ccff_en`, input, 1: shift enable for the configuration chain.
- `ccff_head`, input, 1: chain serial input.
- `ccff_tail`, output, 1: chain serial output (MSB of the chain).
- `cfg_valid`, output, 1: an active configuration has been committed.
- `cfg_done`, output, 1: one-cycle pulse after a successful commit.
- `cfg_err`, output, 1: sticky parity error. Tied 0 without the macro.

## Operation
- `CHAIN_LEN` = NUM_PADS*3, plus 1 with parity.
- Shifting: on each `prog_clk` edge with `ccff_en`=1, `chain <= {chain[CHAIN_LEN-2:0], ccff_head}`. `ccff_tail` = `chain[CHAIN_LEN-1]`.
- `bit_cnt` is a width of clog2(CHAIN_LEN) bits. It increments on every shift and wraps from CHAIN_LEN-1 to 0.
  - Holds when `ccff_en`=0, so gaps mid-load are legal.
- Commit: on the edge where `ccff_en`=1 and `bit_cnt`==CHAIN_LEN-1:
  - `active_cfg <= {chain[CHAIN_LEN-2:0], ccff_head}`, i.e. the post-shift chain contents.
  - `cfg_valid <= 1`.
  - `cfg_done` is high for the following cycle only.
- `active_cfg` never changes outside a commit. Pads keep their old mode while a new bitstream shifts in.
- Per-pad bits in `active_cfg`, for pad i at base i*3:
  - +0 DIR: 1 = pad driven.
  - +1 IN_REG.
  - +2 OUT_REG.
- Pad drive:
  - When `cfg_valid`=1 and DIR=1, the pad is driven with OUT_REG ? `out_q[i]` : `iopad_outpad[i]`.
  - Otherwise the pad is high-Z.
- Pad input:
  - `iopad_inpad[i]` = IN_REG ? `in_q[i]` : pad value. It is gated to 0 while `cfg_valid`=0.
  - An output-configured pad reads back its own driven value.
- `out_q` and `in_q` sample every cycle regardless of mode.
- Reset (`pReset`=1 at an edge) clears:
  - `chain`, `bit_cnt`, `active_cfg`, `out_q`, `in_q`: all 0.
  - `cfg_valid`=0, `cfg_done`=0, `cfg_err`=0.
  - Pad outputs: all high-Z; `iopad_inpad`=0; `ccff_tail`=0.
- Reset mid-load aborts the load. Reset has priority over a simultaneous commit.

## Timing
- Chain latency: a bit entering `ccff_head` appears on `ccff_tail` CHAIN_LEN shift edges later.
- Commit latency: mode takes effect at the same edge as the last shift. `cfg_done` follows one cycle later.
- IN_REG=1: one-cycle latency, pad to `iopad_inpad`. IN_REG=0: combinational.
- OUT_REG=1: one-cycle latency, `iopad_outpad` to pad. OUT_REG=0: combinational.
- Back-to-back bitstreams with no gap are legal: commits occur every CHAIN_LEN enabled cycles.

## Configuration
- Macro `IO_BANK_PARITY_EN`.
- Defined:
  - CHAIN_LEN gains one bit, at the top, shifted in first. Even parity over all CHAIN_LEN bits.
  - At a commit edge with odd parity: `active_cfg` and `cfg_valid` are unchanged, `cfg_err <= 1`, and no `cfg_done` pulse occurs.
  - A later good commit clears `cfg_err`.
- Undefined: CHAIN_LEN = NUM_PADS*3, no check, `cfg_err` tied 0.
- The port list is identical in both builds.

## Structure
- Package `io_bank_pkg`:
  - `CFG_BITS_PER_PAD`=3.
  - Bit offsets `CFG_DIR`=0, `CFG_IN_REG`=1, `CFG_OUT_REG`=2.
  - Function `chain_len(num_pads)` that honours the macro.
- Sub-module `io_bank_cfg_chain` holds the shift chain, `bit_cnt`, commit, `active_cfg`, `cfg_valid`, `cfg_done` and parity logic.
- The top level instantiates `io_bank_cfg_chain` once and one `GPIO` cell per pad, with the data registers in a generate loop.

## Test plan
- Reset, then NUM_PADS=8 → all pads Z, `iopad_inpad`=0, `cfg_valid`=0, `ccff_tail`=0.
- Shift 24 bits setting pad0 DIR=1/OUT_REG=0 and pad1 IN_REG=1, all others 0:
  - `cfg_valid` rises at the 24th edge and `cfg_done` pulses one cycle later.
  - pad0 follows `iopad_outpad[0]` combinationally.
  - `iopad_inpad[1]` lags pad1 by one cycle.
- Load with `ccff_en` toggled 1/0 every cycle → commit after 24 enabled edges (48 clocks). Old config holds until then.
- Assert `pReset` after 10 shifted bits, then shift a full stream → commit after exactly 24 further bits. Prior `active_cfg` was cleared to 0.
- Shift a walking-1 pattern through → it appears on `ccff_tail` 24 enabled edges later.
- With `IO_BANK_PARITY_EN`, shift 25 bits with bad parity:
  - `cfg_err`=1, `active_cfg` unchanged, no `cfg_done`.
  - A following good stream clears `cfg_err` and pulses `cfg_done`.
